// File: rtl/divisor_secuencial_pkg.sv
// Shared arithmetic-unit definitions: divider FSM states, default operand width
// and the 4-bit carry-lookahead helper equations used by the trial subtractor.
package divisor_secuencial_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIN  = 2'd2
  } div_state_t;

  // Carry into bit idx of a 4-bit group, flattened two-level lookahead form.
  function automatic logic cla_carry(input logic [2:0] g, input logic [2:0] p,
                                     input logic cin, input logic [1:0] idx);
    logic [3:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return c[idx];
  endfunction

  // Group generate / propagate, returned as {G, P}.
  function automatic logic [1:0] cla_block_gp(input logic [3:0] g, input logic [3:0] p);
    logic gg;
    gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {gg, &p};
  endfunction

endpackage

// File: rtl/divisor_secuencial_cla_restador.sv
// N-bit unsigned subtractor a - b as a + ~b + 1 using 4-bit lookahead groups
// chained through group G/P; combinational, borrow is the inverted carry-out.
module cla_restador
  import divisor_secuencial_pkg::*;
#(
  parameter int N = DEF_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NB = (N + 3) / 4;
  localparam int P  = 4 * NB;

  logic [P-1:0] a_ext, nb_ext, g, p;
  logic [NB:0]  cblk;

  // Both operands zero-extended to whole groups so the final carry is a true borrow.
  assign a_ext   = P'(a);
  assign nb_ext  = ~P'(b);
  assign g       = a_ext & nb_ext;
  assign p       = a_ext ^ nb_ext;
  assign cblk[0] = 1'b1;

  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [1:0] gp;
    assign gp        = cla_block_gp(g[4*k +: 4], p[4*k +: 4]);
    assign cblk[k+1] = gp[1] | (gp[0] & cblk[k]);
  end

  for (genvar i = 0; i < N; i++) begin : g_sum
    assign diff[i] = p[i] ^ cla_carry(g[4*(i/4) +: 3], p[4*(i/4) +: 3], cblk[i/4], 2'(i % 4));
  end

  assign borrow = ~cblk[NB];

endmodule

// File: rtl/divisor_secuencial.sv
// Sequential unsigned restoring divider (A/Q/M registers), one quotient bit per clock.
// start sampled in IDLE; done pulses WIDTH+1 cycles later (2 for divide-by-zero).
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_n;
  logic [WIDTH-1:0] a_q, a_n, q_q, q_n, m_q, m_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n, dbz_n;
  logic [WIDTH-1:0] quo_n, rem_n;

  logic             idle, borrow, restore;
  logic [WIDTH:0]   sub_a, sub_b, trial;
  logic [WIDTH-2:0] q_low;
  logic [WIDTH-1:0] a_iter, q_iter;

  // The accepting IDLE edge already performs the first iteration on the raw
  // operands (A=0), so RUN needs only WIDTH-1 further cycles.
  assign idle  = (state == DIV_IDLE);
  assign sub_a = idle ? {{WIDTH{1'b0}}, dividend[WIDTH-1]} : {a_q, q_q[WIDTH-1]};
  assign sub_b = {1'b0, idle ? divisor : m_q};
  assign q_low = idle ? dividend[WIDTH-2:0] : q_q[WIDTH-2:0];

  cla_restador #(.N(WIDTH + 1)) u_sub (
    .a      (sub_a),
    .b      (sub_b),
    .diff   (trial),
    .borrow (borrow)
  );

  // Operands are zero-extended, so the difference MSB and the carry-out agree.
  assign restore = borrow | trial[WIDTH];
  assign a_iter  = restore ? sub_a[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_iter  = {q_low, ~restore};

  always_comb begin
    state_n = state;
    a_n     = a_q;
    q_n     = q_q;
    m_n     = m_q;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    quo_n   = quotient;
    rem_n   = remainder;
    dbz_n   = div_by_zero;
    case (state)
      DIV_IDLE: begin
        if (start) begin
          cnt_n = '0;
          if (divisor == '0) begin
            a_n     = dividend;
            q_n     = '1;
            dbz_n   = 1'b1;
            state_n = DIV_FIN;
          end else begin
            a_n     = a_iter;
            q_n     = q_iter;
            m_n     = divisor;
            cnt_n   = CNT_W'(1);
            busy_n  = 1'b1;
            dbz_n   = 1'b0;
            state_n = DIV_RUN;
          end
        end
      end
      DIV_RUN: begin
        a_n   = a_iter;
        q_n   = q_iter;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(WIDTH - 1)) state_n = DIV_FIN;
      end
      DIV_FIN: begin
        quo_n   = q_q;
        rem_n   = a_q;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = DIV_IDLE;
      end
      default: state_n = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DIV_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      a_q         <= a_n;
      q_q         <= q_n;
      m_q         <= m_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      done        <= done_n;
      quotient    <= quo_n;
      remainder   <= rem_n;
      div_by_zero <= dbz_n;
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// Bench for divisor_secuencial: directed operations plus a random sweep, checked
// every cycle against an arithmetic timing model and a table of literal results.
module tb_divisor_secuencial;

  localparam int WIDTH = 8;

  logic             clk, rst_n, start;
  logic [WIDTH-1:0] dividend, divisor;
  logic             busy, done, div_by_zero;
  logic [WIDTH-1:0] quotient, remainder;

  divisor_secuencial #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Model: an accepted request finishes WIDTH edges later (1 for divisor 0),
  // results come from / and %, and the block is free one edge after finishing.
  int               m_e = 0, fin_e = -1, free_e = 0;
  logic [WIDTH-1:0] pend_q, pend_r;
  logic             pend_dbz;
  logic             exp_busy = 0, exp_done = 0, exp_dbz = 0;
  logic [WIDTH-1:0] exp_q = 0, exp_r = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_e = 0; fin_e = -1; free_e = 0;
      exp_busy = 0; exp_done = 0; exp_dbz = 0; exp_q = 0; exp_r = 0;
    end else begin
      m_e = m_e + 1;
      exp_done = 0;
      if (m_e == fin_e) begin
        exp_q = pend_q; exp_r = pend_r; exp_dbz = pend_dbz;
        exp_done = 1; exp_busy = 0;
      end else if (start && m_e >= free_e) begin
        if (divisor == 0) begin
          pend_q = '1; pend_r = dividend; pend_dbz = 1; exp_dbz = 1;
          fin_e = m_e + 1; free_e = m_e + 2;
        end else begin
          pend_q = dividend / divisor; pend_r = dividend % divisor; pend_dbz = 0;
          exp_dbz = 0; exp_busy = 1;
          fin_e = m_e + WIDTH; free_e = m_e + WIDTH + 1;
        end
      end
    end
  end

  // Hand-computed results of the directed operations, in done order.
  int lit_q   [9] = '{14, 255, 0, 1, 255, 3, 14, 10, 9};
  int lit_r   [9] = '{2, 0, 5, 0, 37, 0, 2, 0, 0};
  int lit_z   [9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  int lit_lat [9] = '{9, 9, 9, 9, 2, 9, 9, 9, 9};

  int checks = 0, errors = 0;
  int base = 0, cur_a = 0, cur_b = 1, wd = 0;

  task automatic check(input string nm, input int act, input int want);
    checks = checks + 1;
    if (act != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  initial begin : compare
    int n_done;
    int wd_seen;
    n_done  = 0;
    wd_seen = 0;
    forever begin
      @(negedge clk);
      check("busy", int'(busy), int'(exp_busy));
      check("done", int'(done), int'(exp_done));
      check("quotient", int'(quotient), int'(exp_q));
      check("remainder", int'(remainder), int'(exp_r));
      check("div_by_zero", int'(div_by_zero), int'(exp_dbz));
      if (done && rst_n) begin
        if (n_done < 9) begin
          check("lit_quotient", int'(quotient), lit_q[n_done]);
          check("lit_remainder", int'(remainder), lit_r[n_done]);
          check("lit_dbz", int'(div_by_zero), lit_z[n_done]);
          check("lit_latency", cyc - base, lit_lat[n_done]);
        end else begin
          check("q*d+r==a", int'(quotient) * cur_b + int'(remainder), cur_a);
          check("r<d", int'(remainder < WIDTH'(cur_b)), 1);
        end
        n_done = n_done + 1;
      end
      if (wd != wd_seen) begin
        check("done_timeout", wd, wd_seen);
        wd_seen = wd;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input int a, input int b);
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    base     = cyc;
    cur_a    = a;
    cur_b    = b;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) return;
    end
    wd = wd + 1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    do_op(100, 7);  wait_done();
    do_op(255, 1);  wait_done();
    do_op(5, 9);    wait_done();
    do_op(200, 200); wait_done();
    do_op(37, 0);   wait_done();
    do_op(9, 3);    wait_done();

    // Request while busy must be ignored; a request in the done cycle is accepted.
    do_op(100, 7);
    for (int k = 0; k < 20 && cyc != base + 4; k++) tick();
    dividend = 8'd50; divisor = 8'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    do_op(50, 5);   wait_done();

    // Reset in the middle of an operation aborts it.
    do_op(100, 7);
    for (int k = 0; k < 20 && cyc != base + 4; k++) tick();
    @(posedge clk); #2 rst_n = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    tick();
    do_op(81, 9);   wait_done();

    for (int i = 0; i < 1000; i++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
      wait_done();
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
